// File: rtl/magma_ecb_engine.sv
// ---------------------------------------------------------------------------
// magma_ecb_engine
//
// Iterative GOST R 34.12-2015 "Magma" block cipher core (64-bit block,
// 256-bit key). The data word carries N_BLOCKS independent 64-bit blocks that
// are processed side by side in ECB fashion with the same key and mode;
// block n occupies data_in[64*n +: 64], so with N_BLOCKS=2 the upper half
// (hi) is data_in[127:64] and the lower half (lo) is data_in[63:0].
//
// Parameters
//   UNROLL    rounds applied per clock in RUN; legal values 1, 2, 4, 8
//   N_BLOCKS  number of parallel 64-bit blocks
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   one-cycle request, accepted only while busy==0
//   data_in    in   plaintext/ciphertext, sampled on accepted start
//   key        in   256-bit key, sampled on accepted start (K1=key[255:224])
//   encr_decr  in   0=encrypt, 1=decrypt, sampled on accepted start
//   data_out   out  result, valid from the done pulse until the next result
//   done       out  one-cycle pulse in the cycle data_out takes a new result
//   busy       out  high from the cycle after an accepted start through the
//                   cycle of done
//
// Handshake: the request is accepted on the rising edge where start==1 and
// the engine is idle (busy==0). Requests while busy are dropped, not queued.
// Completion is signalled by done for exactly one cycle; data_out is stable
// from that cycle until the next completion (or reset).
//
// Timing (R = 32/UNROLL): accept at edge e0, round edges e0+1..e0+R, done and
// data_out appear after edge e0+R (FIN cycle, busy still high), the engine is
// back in IDLE after edge e0+R+1 and can accept at edge e0+R+2.
// ---------------------------------------------------------------------------
module magma_ecb_engine #(
  parameter int UNROLL   = 1,
  parameter int N_BLOCKS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [64*N_BLOCKS-1:0]  data_in,
  input  logic [255:0]            key,
  input  logic                    encr_decr,
  output logic [64*N_BLOCKS-1:0]  data_out,
  output logic                    done,
  output logic                    busy
);

  localparam int DW = 64 * N_BLOCKS;

  // S-box tables pi0..pi7. Nibble i of PI[j] (bits [4i+3:4i]) is pi_j(i).
  localparam logic [63:0] PI [8] = '{
    64'h1f307d8e9b5a264c,   // pi0
    64'hf0db74e1c5a93286,   // pi1
    64'h069c471edaf2853b,   // pi2
    64'hb9e35a076f4d128c,   // pi3
    64'hc24be390d618a5f7,   // pi4
    64'h0e34187bac296fd5,   // pi5
    64'h73ad0b4fc19652e8,   // pi6
    64'h2bc96af43850de71    // pi7
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [5:0]        ctr;       // rounds completed so far, 0..32
  logic [DW-1:0]     blk;       // working cipher state of all blocks
  logic [255:0]      key_q;     // key latched at acceptance
  logic              mode_q;    // encr_decr latched at acceptance
  logic [DW-1:0]     next_blk;  // blk after UNROLL more rounds

  // Key words K1..K8 as an array indexed 0..7 (key_w[0] = K1).
  logic [31:0] key_w [8];
  for (genvar j = 0; j < 8; j++) begin : g_key_words
    assign key_w[j] = key_q[255-32*j -: 32];
  end

  // g_k(a) = rotl11(S(a + k mod 2^32))
  function automatic logic [31:0] g_fn(input logic [31:0] a,
                                       input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] sb;
    s  = a + k;
    sb = '0;
    for (int j = 0; j < 8; j++) begin
      sb[4*j +: 4] = PI[j][{s[4*j +: 4], 2'b00} +: 4];
    end
    return {sb[20:0], sb[31:21]};
  endfunction

  // Round-key index (0 = K1) for 0-based round idx.
  // Encrypt: three forward passes then one reversed pass (rounds 24..31).
  // Decrypt: one forward pass then three reversed passes (rounds 8..31).
  // Within a reversed pass the index is simply the complement of idx[2:0].
  function automatic logic [2:0] key_sel(input logic [4:0] idx,
                                         input logic       dec);
    logic rev;
    rev = dec ? (idx[4:3] != 2'b00) : (idx[4:3] == 2'b11);
    return rev ? ~idx[2:0] : idx[2:0];
  endfunction

  // Combinational chain of UNROLL rounds over every block.
  logic [63:0] rb;
  logic [31:0] rt;
  logic [4:0]  ridx;

  always_comb begin
    next_blk = blk;
    rb       = '0;
    rt       = '0;
    ridx     = '0;
    for (int n = 0; n < N_BLOCKS; n++) begin
      rb = blk[64*n +: 64];
      for (int u = 0; u < UNROLL; u++) begin
        ridx = ctr[4:0] + 5'(u);
        rt   = g_fn(rb[31:0], key_w[key_sel(ridx, mode_q)]) ^ rb[63:32];
        // The last round writes the new half on top and keeps a0 below,
        // i.e. it omits the half swap.
        if (ridx == 5'd31) begin
          rb = {rt, rb[31:0]};
        end else begin
          rb = {rb[31:0], rt};
        end
      end
      next_blk[64*n +: 64] = rb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ctr      <= '0;
      blk      <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            blk    <= data_in;
            key_q  <= key;
            mode_q <= encr_decr;
            ctr    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          blk <= next_blk;
          ctr <= ctr + 6'(UNROLL);
          // On the edge completing round 32 the result is published so that
          // done and data_out are both visible during the FIN cycle.
          if (ctr + 6'(UNROLL) == 6'd32) begin
            data_out <= next_blk;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
